// File: rtl/score_digit_renderer_if.sv
// Row-beat stream from the score digit renderer to the display writer.
interface score_digit_renderer_if;
  logic [4:0] row_data_out;
  logic [2:0] row_digit_out;
  logic [2:0] row_idx_out;
  logic       row_valid_out;
  logic       row_ready_in;

  modport master (
    output row_data_out,
    output row_digit_out,
    output row_idx_out,
    output row_valid_out,
    input  row_ready_in
  );

  modport slave (
    input  row_data_out,
    input  row_digit_out,
    input  row_idx_out,
    input  row_valid_out,
    output row_ready_in
  );
endinterface

// File: rtl/score_digit_renderer.sv
// Converts a binary score to BCD (shift-add-3, one bit per cycle) and streams the
// 8x5 glyph rows of each decimal digit, most significant digit first.
module score_digit_renderer #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned VALUE_WIDTH   = 14,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      start_in,
  input  logic [VALUE_WIDTH-1:0]    value_in,
  output logic [7:0]                glyph_ind_out,
  input  logic [7:0][4:0]           glyph_in,
  output logic                      busy_out,
  output logic                      done_out,
  score_digit_renderer_if.master    row_if
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(VALUE_WIDTH + 1);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint unsigned SAT_MAX = pow10(NUM_DIGITS) - 1;
  localparam logic [BCD_W-1:0] NINES  = {NUM_DIGITS{4'h9}};

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT, S_DONE} state_t;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  // Digit 0 is the most significant nibble.
  function automatic logic [3:0] nib_at(input logic [BCD_W-1:0] b, input int d);
    return b[(int'(NUM_DIGITS) - 1 - d) * 4 +: 4];
  endfunction

  function automatic logic blank_at(input logic [BCD_W-1:0] b, input int d);
    logic nonzero;
    nonzero = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++)
      if (i <= d && b[(int'(NUM_DIGITS) - 1 - i) * 4 +: 4] != 4'd0) nonzero = 1'b1;
    return (BLANK_LEADING != 0) && !nonzero && (d != int'(NUM_DIGITS) - 1);
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [VALUE_WIDTH-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   sat_q, sat_d;
  logic [7:0]             glyph_q, glyph_d;
  logic [2:0]             digit_q, digit_d;
  logic [2:0]             idx_q, idx_d;
  logic                   valid_q, valid_d;
  logic                   blank_q, blank_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [BCD_W+VALUE_WIDTH-1:0] shifted;
  logic [BCD_W-1:0]             bcd_final;

  assign shifted   = {add3(bcd_q), shift_q} << 1;
  assign bcd_final = sat_q ? NINES : shifted[BCD_W+VALUE_WIDTH-1 -: BCD_W];

  // State and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      bcd_q   <= '0;
      sat_q   <= 1'b0;
      glyph_q <= '0;
      digit_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      sat_q   <= sat_d;
      glyph_q <= glyph_d;
      digit_q <= digit_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    sat_d   = sat_q;
    glyph_d = glyph_q;
    digit_d = digit_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    blank_d = blank_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start_in) begin
          state_d = S_CONVERT;
          shift_d = value_in;
          bcd_d   = '0;
          sat_d   = 64'(value_in) > SAT_MAX;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      S_CONVERT: begin
        shift_d = shifted[VALUE_WIDTH-1:0];
        bcd_d   = shifted[BCD_W+VALUE_WIDTH-1 -: BCD_W];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VALUE_WIDTH - 1)) begin
          state_d = S_EMIT;
          bcd_d   = bcd_final;
          valid_d = 1'b1;
          digit_d = '0;
          idx_d   = '0;
          glyph_d = 8'(nib_at(bcd_final, 0));
          blank_d = blank_at(bcd_final, 0);
        end
      end

      S_EMIT: begin
        if (valid_q && row_if.row_ready_in) begin
          if (idx_q == 3'd7) begin
            idx_d = '0;
            if (digit_q == 3'(NUM_DIGITS - 1)) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
              digit_d = '0;
              glyph_d = '0;
              blank_d = 1'b0;
            end else begin
              digit_d = digit_q + 3'd1;
              glyph_d = 8'(nib_at(bcd_q, int'(digit_q) + 1));
              blank_d = blank_at(bcd_q, int'(digit_q) + 1);
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign glyph_ind_out        = glyph_q;
  assign busy_out             = busy_q;
  assign done_out             = done_q;
  assign row_if.row_digit_out = digit_q;
  assign row_if.row_idx_out   = idx_q;
  assign row_if.row_valid_out = valid_q;
  // Glyph comes from a combinational ROM addressed by glyph_ind_out in the same cycle.
  assign row_if.row_data_out  = (valid_q && !blank_q) ? glyph_in[idx_q] : 5'b00000;

endmodule
